// File: rtl/hfpu_mul_arb.sv
// Round-robin arbiter sharing one combinational 11x11 mantissa multiplier
// (hfpu_dsp11) between NREQ requesters. Operands are registered toward the
// DSP and the product is captured after MUL_LAT cycles with a one-hot tag.
module hfpu_mul_arb #(
  parameter int NREQ    = 2,
  parameter int W       = 11,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_rdy,
  output logic [NREQ-1:0]   rsp_vld,
  output logic [2*W-1:0]    rsp_p,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  output logic              busy
);

  // Pointer/id width covers up to 4 requesters; counter covers MUL_LAT up to 4.
  localparam int PW = 2;
  localparam int CW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       id_q, id_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        mul_a_q, mul_a_d;
  logic [W-1:0]        mul_b_q, mul_b_d;
  logic [2*W-1:0]      rsp_p_q, rsp_p_d;
  logic [NREQ-1:0]     rsp_vld_q, rsp_vld_d;

  logic                found;
  logic [PW-1:0]       win;
  logic [NREQ-1:0]     gnt;
  logic [W-1:0]        a_sel;
  logic [W-1:0]        b_sel;

  // Round-robin pick: first valid requester at or after the pointer, IDLE only.
  always_comb begin
    found = 1'b0;
    win   = '0;
    gnt   = '0;
    a_sel = '0;
    b_sel = '0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_vld[i] && (((int'(ptr_q) + k) % NREQ) == i)) begin
            found = 1'b1;
            win   = PW'(i);
          end
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (found && (win == PW'(i))) begin
        gnt[i] = 1'b1;
        a_sel  = req_a[i*W +: W];
        b_sel  = req_b[i*W +: W];
      end
    end
  end

  // Next-state: grant and latch operands in IDLE, count down and capture in MUL.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    rsp_p_d   = rsp_p_q;
    rsp_vld_d = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          mul_a_d = a_sel;
          mul_b_d = b_sel;
          id_d    = win;
          ptr_d   = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
          cnt_d   = CW'(MUL_LAT-1);
          state_d = MUL;
        end
      end
      MUL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_p_d = mul_p;
          for (int i = 0; i < NREQ; i++) begin
            rsp_vld_d[i] = (id_q == PW'(i));
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight op and rewinds the RR pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      rsp_p_q   <= '0;
      rsp_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      rsp_p_q   <= rsp_p_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  assign req_rdy = gnt;
  assign rsp_vld = rsp_vld_q;
  assign rsp_p   = rsp_p_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign busy    = (state_q == MUL);

endmodule
